// File: rtl/icache.sv
`default_nettype none
//==============================================================================
// Module   : icache
// Brief    : Direct-mapped, 16-set, single-word-block instruction cache with a
//            blocking single-read miss engine. Define ICACHE_STATS_EN to add
//            hit_count / miss_count statistics outputs.
// Revision : 1.0 - initial release
//==============================================================================

package diaosi_types_pkg;

    typedef struct packed {
        logic [25:0] tag;
        logic        valid;
        logic [31:0] data;
    } Icache_t;

    typedef logic [0:0] Istate_t;
    localparam Istate_t IDLE_I = 1'b0;
    localparam Istate_t LD     = 1'b1;

endpackage

module icache
    import diaosi_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_SETS = 16;

    Icache_t     r_cache [c_SETS];
    Istate_t     r_state;
    Istate_t     w_state_next;
    logic [31:0] r_miss_addr;

    logic [3:0]  w_idx;
    logic [25:0] w_tag;
    Icache_t     w_entry;
    logic        w_hit;
    logic        w_miss;
    logic        w_fill;
    logic        w_unused_ok;

    assign w_idx       = imemaddr[5:2];
    assign w_tag       = imemaddr[31:6];
    assign w_entry     = r_cache[w_idx];
    assign w_unused_ok = &{1'b0, imemaddr[1:0]};

    assign ihit     = w_hit;
    assign imemload = w_entry.data;
    assign iaddr    = r_miss_addr;

    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        iREN         = 1'b0;
        case (r_state)
            IDLE_I: begin
                w_hit  = imemREN && !iflush && w_entry.valid && (w_entry.tag == w_tag);
                w_miss = imemREN && !iflush && !w_hit;
                if (w_miss) begin
                    w_state_next = LD;
                end
            end
            LD: begin
                // The fill always completes, whatever the fetch stage does now.
                iREN   = 1'b1;
                w_fill = !iwait;
                if (!iwait) begin
                    w_state_next = IDLE_I;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE_I;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_miss_addr <= {imemaddr[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < c_SETS; i++) begin
                r_cache[i] <= '0;
            end
        end else begin
            if (iflush) begin
                for (int i = 0; i < c_SETS; i++) begin
                    r_cache[i].valid <= 1'b0;
                end
            end
            // Issued after the flush so freshly read data stays valid.
            if (w_fill) begin
                r_cache[r_miss_addr[5:2]] <= '{tag: r_miss_addr[31:6], valid: 1'b1, data: iload};
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
//==============================================================================
// Module   : tb_icache
// Brief    : Randomised scoreboard bench for icache against a set-level model.
//            Build with ICACHE_STATS_EN to also cover the statistics counters.
// Revision : 1.0 - initial release
//==============================================================================

module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iflush   (iflush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          w;
    } ld_t;

    exp_t sb [$];
    ld_t  ld_q [$];

    // Model: which line currently lives in each set, plus expected counters.
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    int          m_hits = 0;
    int          m_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0040) return 32'h2008_0005;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [25:0] tg;
        case ($urandom_range(0, 3))
            0:       tg = 26'h0;
            1:       tg = 26'h1;
            2:       tg = 26'h2A5;
            default: tg = 26'h3FF_FFFF;
        endcase
        return {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Records a miss launch in the model and returns the cycle the line is usable.
    function automatic int launch_miss(input logic [31:0] a, input int w, input int c);
        ld_q.push_back('{{a[31:2], 2'b00}, w});
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[31:6];
        m_miss++;
        return c + w + 2;
    endfunction

    // Monitor: every ihit must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (nRST && ihit) begin
            if (sb.size() == 0) begin
                chk("unexpected_ihit", imemaddr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hit_cycle", 32'(cyc), 32'(e.cyc));
                chk("imemload", imemload, e.data);
            end
        end
    end

    // Memory responder: serves each expected miss read with its wait count.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_cur  = '0;
    always @(negedge CLK) begin
        if (!nRST) begin
            mem_busy = 1'b0;
            iwait    = 1'b1;
        end else if (iREN) begin
            if (!mem_busy) begin
                if (ld_q.size() == 0) begin
                    chk("unexpected_iREN", iaddr, 32'hFFFF_FFFF);
                    mem_cnt = 0;
                    mem_cur = iaddr;
                end else begin
                    ld_t l;
                    l       = ld_q.pop_front();
                    mem_cnt = l.w;
                    mem_cur = l.addr;
                end
                mem_busy = 1'b1;
            end
            chk("iaddr", iaddr, mem_cur);
            if (mem_cnt > 0) begin
                iwait = 1'b1;
                iload = $urandom;
                mem_cnt--;
            end else begin
                iwait    = 1'b0;
                iload    = mem_word(mem_cur);
                mem_busy = 1'b0;
            end
        end else begin
            if (mem_busy) chk("iREN_dropped", 32'd0, 32'd1);
            mem_busy = 1'b0;
            iwait    = 1'b1;
            iload    = $urandom;
        end
    end

    task automatic fetch(input logic [31:0] a, input int w);
        int exp_cyc;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = 1'b0;
        if (model_hit(a)) exp_cyc = cyc;
        else              exp_cyc = launch_miss(a, w, cyc);
        m_hits++;
        sb.push_back('{a, mem_word(a), exp_cyc});
        while (cyc < exp_cyc) begin
            @(posedge CLK); #1;
        end
    endtask

    // Miss on a, then present (ren_b, b) for the whole fill; optional flush on its last cycle.
    task automatic abandon(input logic [31:0] a, input logic [31:0] b, input logic ren_b,
                           input int w, input bit flush_last);
        int dummy;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = 1'b0;
        if (model_hit(a)) begin
            m_hits++;
            sb.push_back('{a, mem_word(a), cyc});
            return;
        end
        dummy = launch_miss(a, w, cyc);
        for (int k = 1; k <= w + 1; k++) begin
            @(posedge CLK); #1;
            imemREN  = ren_b;
            imemaddr = b;
            iflush   = flush_last && (k == w + 1);
        end
        if (flush_last) begin
            model_clear();
            m_valid[a[5:2]] = 1'b1;
        end
    endtask

    task automatic flush_idle(input logic [31:0] a);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = 1'b1;
        model_clear();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            imemREN  = 1'b0;
            imemaddr = $urandom;
            iflush   = 1'b0;
        end
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        int dummy;
        flush_idle(a);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = 1'b0;
        dummy    = launch_miss(a, 6, cyc);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("rst_iREN", 32'(iREN), 32'd0);
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_clear();
        m_hits = 0;
        m_miss = 0;
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        fetch(a, 1);
        fetch(a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        logic [31:0] a;
        logic [31:0] b;
        int w;

        model_clear();
        for (int i = 0; i < 16; i++) m_tag[i] = '0;
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iflush   = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_ihit", 32'(ihit), 32'd0);
        chk("reset_imemload", imemload, 32'd0);
        chk("reset_iREN", 32'(iREN), 32'd0);
        chk("reset_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);
`endif
        imemREN = 1'b0;
        nRST    = 1'b1;

        // Cold miss, repeat hits, conflict eviction.
        fetch(32'h0000_0040, 2);
        for (int k = 0; k < 4; k++) fetch(32'h0000_0040, 0);
        fetch(32'h0000_0080, 1);
        fetch(32'h0000_0040, 0);
        // Abandoned request, then both lines.
        abandon(32'h0000_0104, 32'h0000_0200, 1'b1, 3, 1'b0);
        fetch(32'h0000_0104, 0);
        fetch(32'h0000_0200, 1);
        // Flush while requesting a resident line, then flush racing a fill.
        flush_idle(32'h0000_0040);
        fetch(32'h0000_0040, 0);
        fetch(32'h0000_0104, 2);
        abandon(32'h0000_0300, 32'h0000_0300, 1'b0, 2, 1'b1);
        fetch(32'h0000_0300, 0);
        fetch(32'h0000_0104, 1);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 99);
            a  = rand_addr();
            b  = rand_addr();
            w  = $urandom_range(0, 4);
            if (op < 70)       fetch(a, w);
            else if (op < 80)  idle($urandom_range(1, 3));
            else if (op < 90)  abandon(a, b, 1'($urandom_range(0, 1)), w, 1'b0);
            else if (op < 95)  flush_idle(a);
            else               abandon(a, b, 1'($urandom_range(0, 1)), w, 1'b1);
        end

        idle(3);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_miss));
`endif

        reset_mid_miss(32'h0000_0284);
        idle(3);
`ifdef ICACHE_STATS_EN
        chk("post_reset_hit_count", hit_count, 32'(m_hits));
        chk("post_reset_miss_count", miss_count, 32'(m_miss));
`endif
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("reads_drained", 32'(ld_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
